// File: rtl/lif_pkg.sv
// Shared types and encodings for the leaky integrate-and-fire neuron array.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    EMIT   = 2'd2
  } state_t;

  localparam logic [1:0] LEAK_HALF = 2'd0;
  localparam logic [1:0] LEAK_3Q   = 2'd1;
  localparam logic [1:0] LEAK_7E   = 2'd2;
  localparam logic [1:0] LEAK_NONE = 2'd3;

endpackage

// File: rtl/lif_core.sv
// Combinational single-neuron timestep: leak, saturating integrate, fire, refractory.
// LIF_SUBTRACT_RESET_EN selects reset-by-subtraction instead of reset-to-zero on fire.
module lif_core
  import lif_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int REF_W = 4
) (
  input  logic [WIDTH-1:0] v,
  input  logic [REF_W-1:0] r,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] threshold,
  input  logic [1:0]       leak_sel,
  input  logic [REF_W-1:0] refrac_cycles,
  output logic [WIDTH-1:0] v_next,
  output logic [REF_W-1:0] r_next,
  output logic             fire
);

  function automatic logic [WIDTH-1:0] leak_apply(input logic [WIDTH-1:0] x,
                                                  input logic [1:0] sel);
    case (sel)
      LEAK_HALF: return x - (x >> 1);
      LEAK_3Q:   return x - (x >> 2);
      LEAK_7E:   return x - (x >> 3);
      default:   return x;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH] ? '1 : s[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] leaked;
  logic [WIDTH-1:0] sum;

  always_comb begin
    leaked = leak_apply(v, leak_sel);
    sum    = sat_add(leaked, c);
    fire   = 1'b0;
    v_next = sum;
    r_next = '0;
    if (r != '0) begin
      // Refractory neurons ignore input and stay clamped at rest.
      r_next = r - REF_W'(1);
      v_next = '0;
    end else if (sum >= threshold) begin
      fire   = 1'b1;
      r_next = refrac_cycles;
`ifdef LIF_SUBTRACT_RESET_EN
      v_next = sum - threshold;
`else
      v_next = '0;
`endif
    end
  end

endmodule

// File: rtl/lif_array.sv
// Time-multiplexed layer of LIF neurons sharing one lif_core; one accepted input
// vector advances every neuron by one timestep. Optional: LIF_SUBTRACT_RESET_EN.
module lif_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8,
  parameter int REF_W     = 4,
  parameter int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_NEURONS*WIDTH-1:0]   in_current,
  input  logic [WIDTH-1:0]             threshold,
  input  logic [1:0]                   leak_sel,
  input  logic [REF_W-1:0]             refrac_cycles,
  output logic                         spike_valid,
  input  logic                         spike_ready,
  output logic [N_NEURONS-1:0]         spike,
  input  logic [IDX_W-1:0]             mon_sel,
  output logic [WIDTH-1:0]             mon_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  state_t                       state;
  logic [IDX_W-1:0]             idx;
  logic [WIDTH-1:0]             v_mem [N_NEURONS];
  logic [REF_W-1:0]             r_mem [N_NEURONS];
  logic [N_NEURONS-1:0]         spike_q;

  logic [N_NEURONS*WIDTH-1:0]   cur_p0;
  logic [WIDTH-1:0]             thr_p0;
  logic [1:0]                   leak_p0;
  logic [REF_W-1:0]             refrac_p0;

  logic [WIDTH-1:0]             v_next;
  logic [REF_W-1:0]             r_next;
  logic                         fire;

  // Stage boundary: timestep parameters latched at accept, swept by idx.
  lif_core #(
    .WIDTH (WIDTH),
    .REF_W (REF_W)
  ) u_core (
    .v             (v_mem[idx]),
    .r             (r_mem[idx]),
    .c             (cur_p0[idx*WIDTH +: WIDTH]),
    .threshold     (thr_p0),
    .leak_sel      (leak_p0),
    .refrac_cycles (refrac_p0),
    .v_next        (v_next),
    .r_next        (r_next),
    .fire          (fire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      spike_q   <= '0;
      cur_p0    <= '0;
      thr_p0    <= '0;
      leak_p0   <= '0;
      refrac_p0 <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_mem[i] <= '0;
        r_mem[i] <= '0;
      end
    end else if (en) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cur_p0    <= in_current;
            thr_p0    <= threshold;
            leak_p0   <= leak_sel;
            refrac_p0 <= refrac_cycles;
            idx       <= '0;
            state     <= UPDATE;
          end
        end
        UPDATE: begin
          v_mem[idx]   <= v_next;
          r_mem[idx]   <= r_next;
          spike_q[idx] <= fire;
          if (idx == LAST_IDX) state <= EMIT;
          else                 idx   <= idx + IDX_W'(1);
        end
        EMIT: begin
          if (spike_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready    = en && (state == IDLE);
  assign spike_valid = (state == EMIT);
  assign spike       = spike_q;
  assign mon_state   = ({1'b0, mon_sel} < (IDX_W+1)'(N_NEURONS)) ? v_mem[mon_sel] : '0;

endmodule

// File: tb/tb_lif_array.sv
// Directed bench for lif_array (N=4, WIDTH=8) with an arithmetic reference model.
module tb_lif_array;

`ifdef LIF_SUBTRACT_RESET_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_current = '0;
  logic [7:0]  threshold = '0;
  logic [1:0]  leak_sel = '0;
  logic [3:0]  refrac_cycles = '0;
  logic        spike_valid;
  logic        spike_ready = 1'b0;
  logic [3:0]  spike;
  logic [1:0]  mon_sel = '0;
  logic [7:0]  mon_state;

  int n_vec = 0;
  int n_err = 0;

  int        m_v [4];
  int        m_r [4];
  logic [3:0] m_spk;

  int         got_v [4];
  logic [3:0] got_sp;

  lif_array #(.N_NEURONS(4), .WIDTH(8), .REF_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_current    (in_current),
    .threshold     (threshold),
    .leak_sel      (leak_sel),
    .refrac_cycles (refrac_cycles),
    .spike_valid   (spike_valid),
    .spike_ready   (spike_ready),
    .spike         (spike),
    .mon_sel       (mon_sel),
    .mon_state     (mon_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: one whole timestep applied at the accepting edge.
  always @(posedge clk or posedge rst) begin : model
    int c, lv, s;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_v[i] <= 0;
        m_r[i] <= 0;
      end
      m_spk <= '0;
    end else if (in_valid && in_ready && en) begin
      for (int i = 0; i < 4; i++) begin
        c = int'(in_current[i*8 +: 8]);
        if (m_r[i] > 0) begin
          m_r[i]   <= m_r[i] - 1;
          m_v[i]   <= 0;
          m_spk[i] <= 1'b0;
        end else begin
          case (leak_sel)
            2'd0:    lv = m_v[i] - m_v[i] / 2;
            2'd1:    lv = m_v[i] - m_v[i] / 4;
            2'd2:    lv = m_v[i] - m_v[i] / 8;
            default: lv = m_v[i];
          endcase
          s = (lv + c > 255) ? 255 : lv + c;
          if (s >= int'(threshold)) begin
            m_spk[i] <= 1'b1;
            m_r[i]   <= int'(refrac_cycles);
            m_v[i]   <= SUB ? s - int'(threshold) : 0;
          end else begin
            m_spk[i] <= 1'b0;
            m_v[i]   <= s;
          end
        end
      end
    end
  end

  // Compare outputs against the model whenever they are architecturally settled.
  always @(negedge clk) begin
    if (!rst) begin
      if (spike_valid) chk("spike_vs_model", 32'(spike), 32'(m_spk));
      if (spike_valid || in_ready) chk("mon_vs_model", 32'(mon_state), 32'(m_v[mon_sel]));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_step(input logic [31:0] cur, input logic [7:0] thr,
                            input logic [1:0] lk, input logic [3:0] rf);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_current    = cur;
    threshold     = thr;
    leak_sel      = lk;
    refrac_cycles = rf;
    in_valid      = 1'b1;
    chk("in_ready_at_offer", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!spike_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 mon_sel = 2'(k);
      @(negedge clk);
      got_v[k] = int'(mon_state);
    end
    got_sp = spike;
  endtask

  task automatic release_step();
    @(posedge clk);
    #1 spike_ready = 1'b1;
    @(posedge clk);
    #1 spike_ready = 1'b0;
    chk("valid_cleared", 32'(spike_valid), 32'd0);
    chk("ready_after_emit", 32'(in_ready), 32'd1);
  endtask

  task automatic do_step(input logic [31:0] cur, input logic [7:0] thr,
                         input logic [1:0] lk, input logic [3:0] rf);
    start_step(cur, thr, lk, rf);
    release_step();
  endtask

  initial begin : stim
    int exp_v1 [4];
    logic [3:0] sp0;

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_spike_valid", 32'(spike_valid), 32'd0);
    chk("rst_spike", 32'(spike), 32'd0);
    chk("rst_mon", 32'(mon_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Integrate and fire, no leak
    exp_v1 = '{30, 60, 90, SUB ? 20 : 0};
    for (int s = 0; s < 4; s++) begin
      do_step({24'd0, 8'd30}, 8'd100, 2'd3, 4'd0);
      chk("if_v0", 32'(got_v[0]), 32'(exp_v1[s]));
      chk("if_spike", 32'(got_sp), (s == 3) ? 32'd1 : 32'd0);
    end

    // Leak by half
    do_reset();
    exp_v1 = '{64, 96, 112, 0};
    for (int s = 0; s < 3; s++) begin
      do_step({24'd0, 8'd64}, 8'd255, 2'd0, 4'd0);
      chk("leak_v0", 32'(got_v[0]), 32'(exp_v1[s]));
      chk("leak_spike", 32'(got_sp), 32'd0);
    end

    // Saturation on neuron 1
    do_reset();
    do_step({16'd0, 8'd200, 8'd0}, 8'd255, 2'd3, 4'd0);
    chk("sat_v1_a", 32'(got_v[1]), 32'd200);
    chk("sat_spike_a", 32'(got_sp), 32'd0);
    do_step({16'd0, 8'd200, 8'd0}, 8'd255, 2'd3, 4'd0);
    chk("sat_v1_b", 32'(got_v[1]), 32'd0);
    chk("sat_spike_b", 32'(got_sp), 32'b0010);

    // Refractory period of two timesteps on neuron 2
    do_reset();
    for (int s = 0; s < 4; s++) begin
      do_step({8'd0, 8'd255, 16'd0}, 8'd10, 2'd3, 4'd2);
      chk("ref_spike2", 32'(got_sp[2]), (s == 0 || s == 3) ? 32'd1 : 32'd0);
      if (s == 1 || s == 2) chk("ref_v2_zero", 32'(got_v[2]), 32'd0);
    end

    // Zero threshold: every neuron fires
    do_reset();
    do_step(32'd0, 8'd0, 2'd3, 4'd0);
    chk("thr0_spike", 32'(got_sp), 32'b1111);

    // Global enable low in IDLE: offer refused
    @(posedge clk);
    #1 en = 1'b0;
    in_current = {4{8'd99}};
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("en0_in_ready", 32'(in_ready), 32'd0);
      chk("en0_no_accept", 32'(spike_valid), 32'd0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    en = 1'b1;
    @(negedge clk);
    chk("en0_v_unchanged", 32'(mon_state), 32'd0);

    // Backpressure in EMIT, with a stray in_valid pulse
    do_reset();
    start_step({8'd0, 8'd0, 8'd0, 8'd120}, 8'd100, 2'd3, 4'd0);
    sp0 = spike;
    chk("bp_spike", 32'(sp0), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 in_valid = (i == 2);
      in_current = {4{8'd77}};
      @(negedge clk);
      chk("bp_valid_held", 32'(spike_valid), 32'd1);
      chk("bp_spike_held", 32'(spike), 32'(sp0));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    en = 1'b0;
    spike_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 chk("en0_emit_held", 32'(spike_valid), 32'd1);
    end
    en = 1'b1;
    @(posedge clk);
    #1 spike_ready = 1'b0;
    chk("bp_release_valid", 32'(spike_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);

    // Reset while idx=2 discards the partial sweep
    @(negedge clk);
    in_current = {4{8'd50}};
    threshold = 8'd200;
    leak_sel = 2'd3;
    refrac_cycles = 4'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("midrst_valid", 32'(spike_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      mon_sel = 2'(k);
      #1 chk("midrst_mon", 32'(mon_state), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_ready", 32'(in_ready), 32'd1);
    do_step({4{8'd50}}, 8'd200, 2'd3, 4'd0);
    chk("post_rst_v3", 32'(got_v[3]), 32'd50);
    chk("post_rst_spike", 32'(got_sp), 32'd0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
